lcd_timing_pipeline: RTL

Parametrised LCD scan-out stage sitting between the frame buffer reader and the GPIO pins driving the panel. It generates the pixel clock/tick, programmable horizontal/vertical timing with real sync pulses, and x/y scan coordinates. It aligns data enable and syncs to a configurable pixel-source latency, then mixes in the white text overlay. Blanking-period RGB is forced to zero. This generalises the fixed 800x480, divide-by-2, one-tick-latency, sync-tied-high output path.

---
 rtl/lcd_timing_pipeline.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_timing_pipeline.sv
// LCD scan-out stage: pixel divider, programmable h/v timing with sync pulses, a latency-matched
// DE/sync pipeline and the text-overlay mix feeding the panel pins.
module lcd_timing_pipeline #(
  parameter int unsigned H_ACTIVE      = 800,
  parameter int unsigned H_FRONT       = 40,
  parameter int unsigned H_SYNC        = 48,
  parameter int unsigned H_BACK        = 40,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FRONT       = 13,
  parameter int unsigned V_SYNC        = 3,
  parameter int unsigned V_BACK        = 29,
  parameter int unsigned CLOCK_DIVIDE  = 2,
  parameter int unsigned PIXEL_LATENCY = 1,
  parameter bit          HS_POLARITY   = 1'b0,
  parameter bit          VS_POLARITY   = 1'b0,
  parameter int unsigned COUNT_WIDTH   = 11
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [23:0]            pixel_rgb_i,
  input  logic                   overlay_bw_i,
  output logic                   pixel_tick_o,
  output logic [COUNT_WIDTH-1:0] x_o,
  output logic [COUNT_WIDTH-1:0] y_o,
  output logic                   next_frame_o,
  output logic [15:0]            frame_count_o,
  output logic                   lcd_clock_o,
  output logic [23:0]            lcd_rgb_o,
  output logic                   lcd_de_o,
  output logic                   lcd_hs_o,
  output logic                   lcd_vs_o
);

  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DivW   = $clog2(CLOCK_DIVIDE);
  localparam int unsigned CW     = COUNT_WIDTH;

  localparam logic [DivW-1:0] DivLast = DivW'(CLOCK_DIVIDE - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLOCK_DIVIDE / 2);

  localparam logic [CW-1:0] HLast      = CW'(HTotal - 1);
  localparam logic [CW-1:0] VLast      = CW'(VTotal - 1);
  localparam logic [CW-1:0] HActive    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActive    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSyncStart = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HSyncEnd   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VSyncStart = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VSyncEnd   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

  // Sync registers hold the active level; pin polarity is applied at the output.
  localparam logic HsInvert = ~HS_POLARITY;
  localparam logic VsInvert = ~VS_POLARITY;

  logic [DivW-1:0] div_q, div_d;
  logic [CW-1:0]   h_q, h_d;
  logic [CW-1:0]   v_q, v_d;
  logic            tick;
  logic            frame_end;
  logic [2:0]      raw;   // {de, hs, vs}
  logic [2:0]      tail;

  logic            pixel_tick_q;
  logic            lcd_clock_q;
  logic            next_frame_q;
  logic [15:0]     frame_count_q;
  logic            de_q, de_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic [23:0]     rgb_q, rgb_d;

  assign tick = (div_q == DivLast);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (!enable_i) begin
        h_d = '0;
        v_d = '0;
      end else if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    raw[2] = (h_q < HActive) && (v_q < VActive);
    raw[1] = (h_q >= HSyncStart) && (h_q < HSyncEnd);
    raw[0] = (v_q >= VSyncStart) && (v_q < VSyncEnd);
  end

  assign frame_end = tick && enable_i && (h_q == HLast) && (v_q == VLast);

  // Delay line matches the pixel source latency so DE/syncs line up with pixel_rgb_i.
  if (PIXEL_LATENCY == 0) begin : g_no_delay
    assign tail = raw;
  end else begin : g_delay
    logic [2:0] dly_q [PIXEL_LATENCY];

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        for (int i = 0; i < int'(PIXEL_LATENCY); i++) begin
          dly_q[i] <= 3'b000;
        end
      end else if (tick) begin
        dly_q[0] <= enable_i ? raw : 3'b000;
        for (int i = 1; i < int'(PIXEL_LATENCY); i++) begin
          dly_q[i] <= enable_i ? dly_q[i-1] : 3'b000;
        end
      end
    end

    assign tail = dly_q[PIXEL_LATENCY-1];
  end

  always_comb begin
    de_d  = 1'b0;
    hs_d  = 1'b0;
    vs_d  = 1'b0;
    rgb_d = '0;
    if (enable_i) begin
      de_d = tail[2];
      hs_d = tail[1];
      vs_d = tail[0];
      if (tail[2]) begin
        rgb_d = overlay_bw_i ? 24'hFF_FFFF : pixel_rgb_i;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      pixel_tick_q  <= 1'b0;
      lcd_clock_q   <= 1'b0;
      next_frame_q  <= 1'b0;
      frame_count_q <= '0;
      de_q          <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      rgb_q         <= '0;
    end else begin
      div_q        <= div_d;
      h_q          <= h_d;
      v_q          <= v_d;
      pixel_tick_q <= tick;
      // Registered from div_d so the panel clock falls on the same edge the data changes.
      lcd_clock_q  <= (div_d >= DivHalf);
      next_frame_q <= frame_end;
      if (frame_end) begin
        frame_count_q <= frame_count_q + 1'b1;
      end
      if (tick) begin
        de_q  <= de_d;
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        rgb_q <= rgb_d;
      end
    end
  end

  assign pixel_tick_o  = pixel_tick_q;
  assign x_o           = h_q;
  assign y_o           = v_q;
  assign next_frame_o  = next_frame_q;
  assign frame_count_o = frame_count_q;
  assign lcd_clock_o   = lcd_clock_q;
  assign lcd_rgb_o     = rgb_q;
  assign lcd_de_o      = de_q;
  assign lcd_hs_o      = hs_q ^ HsInvert;
  assign lcd_vs_o      = vs_q ^ VsInvert;

endmodule
